// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: four coin denominations, NUM_ITEMS products
// with per-item prices and stock counters, greedy coin-by-coin change return.
// Latency: every output is registered, so each response appears one clock after the input that caused it.
// Backpressure: while change_ack is low the presented change coin holds, and coins/selects are refused while busy.
//
// Ports:
//   clk, reset                       clock and async active-high reset
//   coin_valid/coin_value            coin strobe, code 0=1 1=2 2=5 3=10
//   sel_valid/sel_item               product select strobe and index
//   cancel                           refund request (honoured in CREDIT only)
//   change_ack                       hopper took the presented change coin
//   vend_valid/vend_item             one-cycle dispense pulse and product
//   change_valid/change_coin         change coin presented to the hopper
//   credit                           current credit in rupees
//   coin_reject/sel_reject           one-cycle refusal pulses
//   busy                             high while in VEND or CHANGE
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int MAX_CREDIT = 50,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3,
  localparam int ITEM_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_item,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                vend_valid,
  output logic [ITEM_W-1:0]   vend_item,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  // Rupee value of a coin code.
  function automatic logic [CREDIT_W-1:0] coin_amount(input logic [1:0] code);
    logic [CREDIT_W-1:0] amt;
    case (code)
      2'd0:    amt = CREDIT_W'(1);
      2'd1:    amt = CREDIT_W'(2);
      2'd2:    amt = CREDIT_W'(5);
      default: amt = CREDIT_W'(10);
    endcase
    return amt;
  endfunction

  // Largest denomination not exceeding the remaining credit. Only called with
  // credit > 0, so the returned coin never drives credit below zero.
  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
    logic [1:0] code;
    if (c >= CREDIT_W'(10))      code = 2'd3;
    else if (c >= CREDIT_W'(5))  code = 2'd2;
    else if (c >= CREDIT_W'(2))  code = 2'd1;
    else                         code = 2'd0;
    return code;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic                vend_valid_q, vend_valid_d;
  logic [ITEM_W-1:0]   vend_item_q, vend_item_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_coin_q, change_coin_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_reject_q, sel_reject_d;
  logic                busy_q, busy_d;

  // Price and stock of the currently selected item.
  logic [CREDIT_W-1:0] price_sel;
  logic [STOCK_W-1:0]  stock_sel;
  logic                sel_in_range;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;
  logic                sel_ok;

  always_comb begin
    price_sel = '0;
    stock_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == ITEM_W'(i)) begin
        price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
        stock_sel = stock_q[i];
      end
    end
  end

  assign sel_in_range = (32'(sel_item) < 32'(NUM_ITEMS));
  // One extra bit so the sum cannot wrap before the ceiling compare.
  assign credit_sum   = {1'b0, credit_q} + {1'b0, coin_amount(coin_value)};
  assign coin_fits    = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_ok       = sel_in_range && (credit_q >= price_sel) && (stock_sel != '0);

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    vend_valid_d   = 1'b0;
    vend_item_d    = '0;
    change_valid_d = 1'b0;
    change_coin_d  = 2'd0;
    coin_reject_d  = 1'b0;
    sel_reject_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // cancel > select > coin; a coin that loses arbitration is bounced.
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (state_q == ST_CREDIT) begin
            state_d        = ST_CHANGE;
            change_valid_d = 1'b1;
            change_coin_d  = greedy_coin(credit_q);
          end
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_ok) begin
            state_d      = ST_VEND;
            credit_d     = credit_q - price_sel;
            vend_valid_d = 1'b1;
            vend_item_d  = sel_item;
            for (int i = 0; i < NUM_ITEMS; i++) begin
              if (sel_item == ITEM_W'(i)) stock_d[i] = stock_q[i] - 1'b1;
            end
          end else begin
            sel_reject_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_d = credit_sum[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d        = ST_CHANGE;
          change_valid_d = 1'b1;
          change_coin_d  = greedy_coin(credit_q);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_valid_q && change_ack) begin
          credit_d = credit_q - coin_amount(change_coin_q);
          if (credit_d == '0) begin
            state_d = ST_IDLE;
          end else begin
            change_valid_d = 1'b1;
            change_coin_d  = greedy_coin(credit_d);
          end
        end else begin
          // Hopper not ready: keep the same coin on the bus.
          change_valid_d = change_valid_q;
          change_coin_d  = change_coin_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'd0;
      coin_reject_q  <= 1'b0;
      sel_reject_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
      vend_valid_q   <= vend_valid_d;
      vend_item_q    <= vend_item_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      sel_reject_q   <= sel_reject_d;
      busy_q         <= busy_d;
    end
  end

  assign vend_valid   = vend_valid_q;
  assign vend_item    = vend_item_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign sel_reject   = sel_reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: a vector table for the main flows
// plus hand sequences for async reset, stock exhaustion and change draining.
module tb_vending_machine_multi;

  logic       clk;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       change_ack;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [1:0] change_coin;
  logic [7:0] credit;
  logic       coin_reject;
  logic       sel_reject;
  logic       busy;

  vending_machine_multi dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .vend_valid   (vend_valid),
    .vend_item    (vend_item),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .sel_reject   (sel_reject),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       change_ack;
  } in_t;

  typedef struct packed {
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       change_valid;
    logic [1:0] change_coin;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_reject;
    logic       busy;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   failures;
  int   prices [4] = '{5, 10, 15, 20};

  function automatic in_t mk_in(logic cv, logic [1:0] cval, logic sv, logic [1:0] si,
                                logic cn, logic ack);
    return '{cv, cval, sv, si, cn, ack};
  endfunction

  function automatic out_t mk_out(logic vv, logic [1:0] vi, logic chv, logic [1:0] cc,
                                  logic [7:0] cr, logic crj, logic srj, logic b);
    return '{vv, vi, chv, cc, cr, crj, srj, b};
  endfunction

  function automatic int rupees(logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 5;
      default: return 10;
    endcase
  endfunction

  function automatic out_t sample();
    return '{vend_valid, vend_item, change_valid, change_coin, credit,
             coin_reject, sel_reject, busy};
  endfunction

  task automatic add(in_t s, out_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic drive(in_t s);
    coin_valid = s.coin_valid;
    coin_value = s.coin_value;
    sel_valid  = s.sel_valid;
    sel_item   = s.sel_item;
    cancel     = s.cancel;
    change_ack = s.change_ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, out_t e);
    out_t a;
    a = sample();
    tests++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got vv=%0b vi=%0d cv=%0b cc=%0d credit=%0d crj=%0b srj=%0b busy=%0b, required vv=%0b vi=%0d cv=%0b cc=%0d credit=%0d crj=%0b srj=%0b busy=%0b",
               name, a.vend_valid, a.vend_item, a.change_valid, a.change_coin, a.credit,
               a.coin_reject, a.sel_reject, a.busy,
               e.vend_valid, e.vend_item, e.change_valid, e.change_coin, e.credit,
               e.coin_reject, e.sel_reject, e.busy);
    end
  endtask

  // Insert coins adding up to the given amount, one coin per cycle.
  task automatic pay(int amount);
    int left;
    left = amount;
    while (left > 0) begin
      if (left >= 10) begin drive(mk_in(1, 3, 0, 0, 0, 0)); left -= 10; end
      else if (left >= 5) begin drive(mk_in(1, 2, 0, 0, 0, 0)); left -= 5; end
      else if (left >= 2) begin drive(mk_in(1, 1, 0, 0, 0, 0)); left -= 2; end
      else begin drive(mk_in(1, 0, 0, 0, 0, 0)); left -= 1; end
      step();
    end
    drive(mk_in(0, 0, 0, 0, 0, 0));
  endtask

  in_t  idle_in;
  out_t zero_out;

  initial begin
    tests    = 0;
    failures = 0;
    idle_in  = mk_in(0, 0, 0, 0, 0, 0);
    zero_out = mk_out(0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle_in);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", zero_out);
    reset = 1'b0;

    // Coin 10, buy item0 (5), coin during VEND bounced, change 5.
    add(mk_in(1, 3, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 10, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, 0, 0), mk_out(1, 0, 0, 0, 5, 0, 0, 1));
    add(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 1, 2, 5, 1, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    // Credit 8, item1 too expensive, cancel returns 5, 2, 1 with ack stalls.
    add(mk_in(1, 2, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 5, 0, 0, 0));
    add(mk_in(1, 1, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 7, 0, 0, 0));
    add(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 8, 0, 0, 0));
    add(mk_in(0, 0, 1, 1, 0, 0), mk_out(0, 0, 0, 0, 8, 0, 1, 0));
    add(mk_in(0, 0, 0, 0, 1, 0), mk_out(0, 0, 1, 2, 8, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0), mk_out(0, 0, 1, 2, 8, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 1, 1, 3, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      add(mk_in(0, 0, 0, 0, 0, 0), mk_out(0, 0, 1, 1, 3, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 1, 0, 1, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    // Fill to the 50 ceiling, overflow coin bounced.
    for (int i = 1; i <= 10; i++)
      add(mk_in(1, 2, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 8'(5 * i), 0, 0, 0));
    add(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 50, 1, 0, 0));
    // Same-cycle coin and select: select wins, coin bounced, change 30.
    add(mk_in(1, 3, 1, 3, 0, 0), mk_out(1, 3, 0, 0, 30, 1, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 0), mk_out(0, 0, 1, 3, 30, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 1, 3, 20, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 1, 3, 10, 0, 0, 1));
    add(mk_in(0, 0, 0, 0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    // Cancel in IDLE does nothing; the coin it beat is bounced.
    add(mk_in(1, 0, 0, 0, 1, 0), mk_out(0, 0, 0, 0, 0, 1, 0, 0));
    // Credit 7, cancel, then coin+cancel during CHANGE without ack.
    add(mk_in(1, 2, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 5, 0, 0, 0));
    add(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 6, 0, 0, 0));
    add(mk_in(1, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 7, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 1, 0), mk_out(0, 0, 1, 2, 7, 0, 0, 1));
    add(mk_in(1, 3, 0, 0, 1, 0), mk_out(0, 0, 1, 2, 7, 1, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].stim);
      step();
      drive(idle_in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset mid-cycle while presenting change with credit 7.
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_mid_change", zero_out);
    step();
    reset = 1'b0;
    check("reset_released", zero_out);

    // Every item sells exactly three times, the fourth select is refused.
    for (int item = 0; item < 4; item++) begin
      for (int k = 0; k < 3; k++) begin
        pay(prices[item]);
        check($sformatf("credit_item%0d_buy%0d", item, k),
              mk_out(0, 0, 0, 0, 8'(prices[item]), 0, 0, 0));
        drive(mk_in(0, 0, 1, 2'(item), 0, 0));
        step();
        drive(idle_in);
        check($sformatf("vend_item%0d_buy%0d", item, k),
              mk_out(1, 2'(item), 0, 0, 0, 0, 0, 1));
        step();
        check($sformatf("idle_item%0d_buy%0d", item, k), zero_out);
      end
      pay(prices[item]);
      drive(mk_in(0, 0, 1, 2'(item), 0, 0));
      step();
      drive(idle_in);
      check($sformatf("soldout_item%0d", item),
            mk_out(0, 0, 0, 0, 8'(prices[item]), 0, 1, 0));

      // Refund with ack held high; total returned must equal the price.
      begin
        int sum;
        int cyc;
        sum = 0;
        cyc = 0;
        drive(mk_in(0, 0, 0, 0, 1, 1));
        step();
        drive(mk_in(0, 0, 0, 0, 0, 1));
        while (change_valid === 1'b1 && cyc < 16) begin
          sum += rupees(change_coin);
          cyc++;
          step();
        end
        drive(idle_in);
        tests++;
        if (cyc >= 16 || sum != prices[item]) begin
          failures++;
          $display("FAIL refund_item%0d: returned %0d rupees in %0d coins, required %0d",
                   item, sum, cyc, prices[item]);
        end
        check($sformatf("refund_done_item%0d", item), zero_out);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
